// File: rtl/d_pkg.sv
// Shared definitions for the decode stage.
//   - Default widths for instruction, program counter, data and register file.
//   - Instruction field positions for the 24-bit encoding:
//       [23:20] opcode, [19:16] rd, [15:12] rs1, [11:8] rs2, [11:0] imm.
//   - dec_bundle_t: the decoded bundle held in the output register.
//   - decode_fields(): splits an instruction into fields and sign-extends imm.
package d_pkg;

    localparam int INSTR_W = 24;
    localparam int PC_W    = 16;
    localparam int DATA_W  = 16;
    localparam int REG_N   = 16;
    localparam int REG_AW  = $clog2(REG_N);

    localparam int OPC_HI = 23;
    localparam int RD_HI  = 19;
    localparam int RS1_HI = 15;
    localparam int RS2_HI = 11;
    localparam int IMM_W  = 12;

    typedef struct packed {
        logic [3:0]        opcode;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [PC_W-1:0]   pc;
    } dec_bundle_t;

    // Field split only; operands are left at zero and filled in by the caller.
    // The immediate is replicated-sign concatenated and then cut to DATA_W,
    // which sign-extends for wide data and truncates when DATA_W < IMM_W.
    function automatic dec_bundle_t decode_fields(input logic [INSTR_W-1:0] instr,
                                                  input logic [PC_W-1:0]    pc);
        dec_bundle_t b;
        b        = '0;
        b.opcode = instr[OPC_HI -: 4];
        b.rd     = instr[RD_HI  -: REG_AW];
        b.rs1    = instr[RS1_HI -: REG_AW];
        b.rs2    = instr[RS2_HI -: REG_AW];
        b.imm    = DATA_W'({{DATA_W{instr[IMM_W-1]}}, instr[IMM_W-1:0]});
        b.pc     = pc;
        return b;
    endfunction

endpackage

// File: rtl/d_stage_regfile.sv
// Register file for the decode stage.
//   clk_i, rst_i         : clock, synchronous active-high reset (clears all entries)
//   rs1_addr / rs1_data  : combinational read port 1
//   rs2_addr / rs2_data  : combinational read port 2
//   we, waddr, wdata     : synchronous write port
// r0 always reads zero and is never written. A read of the register being
// written in the same cycle returns the write data.
module d_stage_regfile #(
    parameter int  DWIDTH = 16,
    parameter int  NREGS  = 16,
    localparam int RAW    = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [RAW-1:0]    rs1_addr,
    output logic [DWIDTH-1:0] rs1_data,
    input  logic [RAW-1:0]    rs2_addr,
    output logic [DWIDTH-1:0] rs2_data,
    input  logic              we,
    input  logic [RAW-1:0]    waddr,
    input  logic [DWIDTH-1:0] wdata
);

    logic [DWIDTH-1:0] mem [NREGS];

    // NOTE: the whole array is reset because software relies on registers
    // reading zero after reset; this rules out a plain RAM macro.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    // NOTE: each output gets a default before the conditions, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        rs1_data = mem[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (we && waddr == rs1_addr) begin
            rs1_data = wdata;
        end
    end

    always_comb begin
        rs2_data = mem[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (we && waddr == rs2_addr) begin
            rs2_data = wdata;
        end
    end

endmodule

// File: rtl/d_stage.sv
// Decode stage between fetch and execute.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   valid_i, ready_o, instr_i,
//   next_pc_i                    : bundle from fetch (valid/ready handshake)
//   flush_i                      : execute redirect, drops every held bundle
//   valid_o, ready_i             : decoded bundle handshake to execute
//   opcode_o, rd_o, rs1_o, rs2_o,
//   imm_o, op_a_o, op_b_o, pc_o  : registered decode bundle
//   wb_we_i, wb_addr_i, wb_data_i: register writeback from the final stage
// Buffering is an output register plus one skid register, so ready_o depends
// only on local state and never on ready_i.
module d_stage
    import d_pkg::*;
#(
    parameter int  IWIDTH = INSTR_W,
    parameter int  PWIDTH = PC_W,
    parameter int  DWIDTH = DATA_W,
    parameter int  NREGS  = REG_N,
    localparam int RAW    = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [IWIDTH-1:0] instr_i,
    input  logic [PWIDTH-1:0] next_pc_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [3:0]        opcode_o,
    output logic [RAW-1:0]    rd_o,
    output logic [RAW-1:0]    rs1_o,
    output logic [RAW-1:0]    rs2_o,
    output logic [DWIDTH-1:0] imm_o,
    output logic [DWIDTH-1:0] op_a_o,
    output logic [DWIDTH-1:0] op_b_o,
    output logic [PWIDTH-1:0] pc_o,
    input  logic              wb_we_i,
    input  logic [RAW-1:0]    wb_addr_i,
    input  logic [DWIDTH-1:0] wb_data_i
);

    logic              or_valid;
    logic              skid_valid;
    dec_bundle_t       or_q;
    dec_bundle_t       ld_fields;
    logic [IWIDTH-1:0] skid_instr;
    logic [PWIDTH-1:0] skid_pc;
    logic [IWIDTH-1:0] ld_instr;
    logic [PWIDTH-1:0] ld_pc;
    logic [DWIDTH-1:0] rd_a;
    logic [DWIDTH-1:0] rd_b;
    logic              in_xfer;
    logic              out_xfer;
    logic              or_free;

    assign ready_o  = !skid_valid && !rst_i;
    assign in_xfer  = valid_i && ready_o;
    assign out_xfer = or_valid && ready_i;
    assign or_free  = !or_valid || out_xfer;

    // The skid entry is always older than anything on the input, so it wins.
    // While it is occupied ready_o is low, so both can never compete.
    assign ld_instr  = skid_valid ? skid_instr : instr_i;
    assign ld_pc     = skid_valid ? skid_pc    : next_pc_i;
    assign ld_fields = decode_fields(ld_instr, ld_pc);

    // Operands are read for whichever bundle is about to enter the output
    // register; the regfile bypass covers a writeback in that same cycle.
    d_stage_regfile #(
        .DWIDTH (DWIDTH),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rs1_addr (ld_fields.rs1),
        .rs1_data (rd_a),
        .rs2_addr (ld_fields.rs2),
        .rs2_data (rd_b),
        .we       (wb_we_i),
        .waddr    (wb_addr_i),
        .wdata    (wb_data_i)
    );

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            or_valid   <= 1'b0;
            skid_valid <= 1'b0;
            or_q       <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (flush_i) begin
            or_valid   <= 1'b0;
            skid_valid <= 1'b0;
        end else if (or_free) begin
            if (skid_valid || in_xfer) begin
                or_valid    <= 1'b1;
                or_q        <= ld_fields;
                or_q.op_a   <= rd_a;
                or_q.op_b   <= rd_b;
                skid_valid  <= 1'b0;
            end else begin
                or_valid <= 1'b0;
            end
        end else begin
            if (in_xfer) begin
                skid_valid <= 1'b1;
                skid_instr <= instr_i;
                skid_pc    <= next_pc_i;
            end
            // Stalled bundle: track writebacks so operands are current when
            // execute finally accepts it. r0 is never refreshed.
            if (wb_we_i && wb_addr_i != '0 && wb_addr_i == or_q.rs1) begin
                or_q.op_a <= wb_data_i;
            end
            if (wb_we_i && wb_addr_i != '0 && wb_addr_i == or_q.rs2) begin
                or_q.op_b <= wb_data_i;
            end
        end
    end

    assign valid_o  = or_valid;
    assign opcode_o = or_q.opcode;
    assign rd_o     = or_q.rd;
    assign rs1_o    = or_q.rs1;
    assign rs2_o    = or_q.rs2;
    assign imm_o    = or_q.imm;
    assign op_a_o   = or_q.op_a;
    assign op_b_o   = or_q.op_b;
    assign pc_o     = or_q.pc;

endmodule

// File: tb/tb_d_stage.sv
module tb_d_stage;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [23:0] instr_i;
    logic [15:0] next_pc_i;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic [3:0]  opcode_o;
    logic [3:0]  rd_o;
    logic [3:0]  rs1_o;
    logic [3:0]  rs2_o;
    logic [15:0] imm_o;
    logic [15:0] op_a_o;
    logic [15:0] op_b_o;
    logic [15:0] pc_o;
    logic        wb_we_i;
    logic [3:0]  wb_addr_i;
    logic [15:0] wb_data_i;

    always #5 clk = ~clk;

    d_stage dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .instr_i   (instr_i),
        .next_pc_i (next_pc_i),
        .flush_i   (flush_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .opcode_o  (opcode_o),
        .rd_o      (rd_o),
        .rs1_o     (rs1_o),
        .rs2_o     (rs2_o),
        .imm_o     (imm_o),
        .op_a_o    (op_a_o),
        .op_b_o    (op_b_o),
        .pc_o      (pc_o),
        .wb_we_i   (wb_we_i),
        .wb_addr_i (wb_addr_i),
        .wb_data_i (wb_data_i)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [23:0] instr, input logic [15:0] pc);
        valid_i   = 1'b1;
        instr_i   = instr;
        next_pc_i = pc;
    endtask

    task automatic idle();
        valid_i = 1'b0;
        flush_i = 1'b0;
        wb_we_i = 1'b0;
    endtask

    // Scoreboard: accepted bundles in order, plus a reference register file.
    // A held operand always equals the current register value (load-time
    // bypass plus refresh while stalled), so expected operands come from rf_m.
    typedef struct packed {
        logic [23:0] instr;
        logic [15:0] pc;
    } sb_item_t;

    sb_item_t    sb_q[$];
    sb_item_t    e_m;
    logic [15:0] rf_m [16];
    logic [15:0] exp_imm;

    initial begin
        for (int i = 0; i < 16; i++) rf_m[i] = '0;
    end

    always @(negedge clk) begin
        if (rst_i) begin
            sb_q.delete();
            for (int i = 0; i < 16; i++) rf_m[i] = '0;
        end else begin
            if (valid_o && ready_i) begin
                check("sb_out_expected", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    e_m     = sb_q.pop_front();
                    exp_imm = {{4{e_m.instr[11]}}, e_m.instr[11:0]};
                    check("sb_pc",     32'(pc_o),     32'(e_m.pc));
                    check("sb_opcode", 32'(opcode_o), 32'(e_m.instr[23:20]));
                    check("sb_rd",     32'(rd_o),     32'(e_m.instr[19:16]));
                    check("sb_rs1",    32'(rs1_o),    32'(e_m.instr[15:12]));
                    check("sb_rs2",    32'(rs2_o),    32'(e_m.instr[11:8]));
                    check("sb_imm",    32'(imm_o),    32'(exp_imm));
                    check("sb_op_a",   32'(op_a_o),   32'(rf_m[e_m.instr[15:12]]));
                    check("sb_op_b",   32'(op_b_o),   32'(rf_m[e_m.instr[11:8]]));
                end
            end
            if (flush_i) begin
                sb_q.delete();
            end else if (valid_i && ready_o) begin
                sb_q.push_back('{instr: instr_i, pc: next_pc_i});
            end
            if (wb_we_i && wb_addr_i != 4'd0) rf_m[wb_addr_i] = wb_data_i;
        end
    end

    typedef struct {
        logic [23:0] instr;
        logic [15:0] pc;
        logic [3:0]  opc;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [15:0] imm;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{24'h000000, 16'h0001, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000};
        vecs[1] = '{24'hFFFFFF, 16'hFFFF, 4'hF, 4'hF, 4'hF, 4'hF, 16'hFFFF};
        vecs[2] = '{24'h123456, 16'h1234, 4'h1, 4'h2, 4'h3, 4'h4, 16'h0456};
        vecs[3] = '{24'h9AB7FF, 16'h0100, 4'h9, 4'hA, 4'hB, 4'h7, 16'h07FF};
        vecs[4] = '{24'h45E800, 16'h0200, 4'h4, 4'h5, 4'hE, 4'h8, 16'hF800};
        vecs[5] = '{24'hC0F0AB, 16'h8000, 4'hC, 4'h0, 4'hF, 4'h0, 16'h00AB};

        rst_i = 1'b1; valid_i = 1'b0; instr_i = '0; next_pc_i = '0;
        flush_i = 1'b0; ready_i = 1'b0; wb_we_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
        tick(); tick(); tick();

        // Reset state
        check("rst_ready",  32'(ready_o),  32'd0);
        check("rst_valid",  32'(valid_o),  32'd0);
        check("rst_opcode", 32'(opcode_o), 32'd0);
        check("rst_op_a",   32'(op_a_o),   32'd0);
        check("rst_pc",     32'(pc_o),     32'd0);
        rst_i = 1'b0;
        #1;
        check("ready_after_rst", 32'(ready_o), 32'd1);

        // Single bundle; bit 11 of 0xC07 is set, so the immediate sign-extends
        drive(24'h3A5C07, 16'h0011);
        ready_i = 1'b1;
        tick();
        idle();
        check("t1_valid",  32'(valid_o),  32'd1);
        check("t1_opcode", 32'(opcode_o), 32'd3);
        check("t1_rd",     32'(rd_o),     32'd10);
        check("t1_rs1",    32'(rs1_o),    32'd5);
        check("t1_rs2",    32'(rs2_o),    32'd12);
        check("t1_imm",    32'(imm_o),    32'h0000FC07);
        check("t1_pc",     32'(pc_o),     32'h0011);
        check("t1_op_a",   32'(op_a_o),   32'd0);
        check("t1_op_b",   32'(op_b_o),   32'd0);
        tick();
        check("t1_drained", 32'(valid_o), 32'd0);

        // Table vectors back to back at full throughput
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].instr, vecs[i].pc);
            tick();
            check("vec_valid",  32'(valid_o),  32'd1);
            check("vec_opcode", 32'(opcode_o), 32'(vecs[i].opc));
            check("vec_rd",     32'(rd_o),     32'(vecs[i].rd));
            check("vec_rs1",    32'(rs1_o),    32'(vecs[i].rs1));
            check("vec_rs2",    32'(rs2_o),    32'(vecs[i].rs2));
            check("vec_imm",    32'(imm_o),    32'(vecs[i].imm));
            check("vec_pc",     32'(pc_o),     32'(vecs[i].pc));
        end
        idle();
        tick();
        check("vec_drained", 32'(valid_o), 32'd0);

        // Writeback bypass at load time
        drive(24'h105000, 16'h0020);
        wb_we_i = 1'b1; wb_addr_i = 4'd5; wb_data_i = 16'h1234;
        tick();
        idle();
        check("byp_op_a", 32'(op_a_o), 32'h1234);
        check("byp_op_b", 32'(op_b_o), 32'd0);
        tick();

        // Stalled operand refresh
        ready_i = 1'b0;
        drive(24'h200700, 16'h0030);
        tick();
        idle();
        check("stall_valid", 32'(valid_o), 32'd1);
        check("stall_op_b0", 32'(op_b_o),  32'd0);
        wb_we_i = 1'b1; wb_addr_i = 4'd7; wb_data_i = 16'hBEEF;
        tick();
        check("stall_op_b", 32'(op_b_o), 32'hBEEF);
        wb_addr_i = 4'd0; wb_data_i = 16'h5555;
        tick();
        wb_we_i = 1'b0;
        check("stall_r0_op_a", 32'(op_a_o),  32'd0);
        check("stall_hold",    32'(valid_o), 32'd1);
        ready_i = 1'b1;
        tick();
        check("stall_drained", 32'(valid_o), 32'd0);

        // Backpressure and skid ordering
        ready_i = 1'b0;
        drive(24'h301100, 16'h000A);
        tick();
        check("skid_ready_a", 32'(ready_o), 32'd1);
        drive(24'h302200, 16'h000B);
        tick();
        check("skid_ready_b", 32'(ready_o), 32'd0);
        check("skid_pc_a",    32'(pc_o),    32'h000A);
        drive(24'h303300, 16'h000C);
        tick();
        check("skid_c_held", 32'(ready_o), 32'd0);
        check("skid_pc_a2",  32'(pc_o),    32'h000A);
        ready_i = 1'b1;
        tick();
        check("skid_pc_b",    32'(pc_o),    32'h000B);
        check("skid_ready_c", 32'(ready_o), 32'd1);
        tick();
        idle();
        check("skid_pc_c", 32'(pc_o),    32'h000C);
        check("skid_v_c",  32'(valid_o), 32'd1);
        tick();
        check("skid_drained", 32'(valid_o), 32'd0);

        // Flush with OR and skid full and a new offer; writeback still lands
        ready_i = 1'b0;
        drive(24'h501100, 16'h000D);
        tick();
        drive(24'h502200, 16'h000E);
        tick();
        check("fl_full", 32'(ready_o), 32'd0);
        drive(24'h503300, 16'h000F);
        flush_i = 1'b1;
        wb_we_i = 1'b1; wb_addr_i = 4'd3; wb_data_i = 16'h3333;
        tick();
        idle();
        check("fl_valid", 32'(valid_o), 32'd0);
        check("fl_ready", 32'(ready_o), 32'd1);
        ready_i = 1'b1;
        tick();
        tick();
        check("fl_quiet", 32'(valid_o), 32'd0);
        drive(24'h603000, 16'h0040);
        tick();
        idle();
        check("fl_wb_op_a", 32'(op_a_o), 32'h3333);
        check("fl_wb_pc",   32'(pc_o),   32'h0040);
        tick();

        // Mid-stream reset with OR and skid full
        ready_i = 1'b0;
        drive(24'h315500, 16'h0050);
        tick();
        drive(24'h327700, 16'h0051);
        tick();
        idle();
        rst_i = 1'b1;
        tick();
        check("mr_valid",  32'(valid_o),  32'd0);
        check("mr_ready",  32'(ready_o),  32'd0);
        check("mr_opcode", 32'(opcode_o), 32'd0);
        check("mr_rd",     32'(rd_o),     32'd0);
        check("mr_rs1",    32'(rs1_o),    32'd0);
        check("mr_rs2",    32'(rs2_o),    32'd0);
        check("mr_imm",    32'(imm_o),    32'd0);
        check("mr_op_a",   32'(op_a_o),   32'd0);
        check("mr_op_b",   32'(op_b_o),   32'd0);
        check("mr_pc",     32'(pc_o),     32'd0);
        rst_i = 1'b0;
        #1;
        check("mr_ready_after", 32'(ready_o), 32'd1);
        ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive({4'h6, 4'h0, 4'(i), 4'(i), 8'h00}, 16'(16'h0100 + i));
            tick();
            check("mr_rf_op_a", 32'(op_a_o), 32'd0);
            check("mr_rf_op_b", 32'(op_b_o), 32'd0);
        end
        idle();
        tick();
        tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
